seq_addsub_pipe: RTL

- Parametrised successor to the team's sequential adder.
- Computes a +/- b over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle LSB-first with a registered carry chain.
- Adds subtract mode, signed/unsigned overflow selection, raw carry-out and a one-cycle done pulse.
- Sits beside the existing adder under the simulation top and is driven by the same start/ready handshake.

---
 rtl/seq_addsub_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/seq_addsub_pipe.sv
// Digit-serial adder/subtractor: a +/- b over WIDTH/DIGIT cycles, LSB slice first,
// with a registered carry between slices and a one-cycle done pulse on completion.
module seq_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             sub,
    input  logic             is_signed,
    output logic [WIDTH-1:0] res,
    output logic             ready,
    output logic             done,
    output logic             overflow,
    output logic             carry_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_param
        $error("seq_addsub_pipe: WIDTH must be a positive multiple of DIGIT");
    end

    logic [0:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             a_msb_q, b_msb_q;
    logic             sub_q, sgn_q;
    logic [WIDTH-1:0] res_q;
    logic             ovf_q, cout_q, done_q;

    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] slice_w;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_d;
    logic             last;

    // Operands shift right each cycle so the active slice is always at bit 0;
    // the result slice enters at the top of acc and settles into place after N steps.
    always_comb begin
        sum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        slice_w = WIDTH'(sum[DIGIT-1:0]);
        acc_d   = (acc_q >> DIGIT) | (slice_w << (WIDTH - DIGIT));
        last    = (cnt_q == CW'(N - 1));
        ovf_d   = sgn_q ? ((a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q))
                        : (sum[DIGIT] ^ sub_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sub_q   <= 1'b0;
            sgn_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1] ^ sub;
                        sub_q   <= sub;
                        sgn_q   <= is_signed;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_d;
                    carry_q <= sum[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= IDLE;
                        res_q   <= acc_d;
                        cout_q  <= sum[DIGIT];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res       = res_q;
    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule
